// File: rtl/vector_list_writer.sv
// vector_list_writer
// Command-driven encoder that appends polylines to the vector display list in
// vector RAM. Each polyline is stored as: length byte L, attribute byte, then
// X,Y byte pairs; a 0 byte terminates the list. The list in RAM stays
// terminated at every instant, and a polyline's length byte is patched last,
// so the renderer only ever sees complete lines.
module vector_list_writer #(
  parameter int VECTOR_RAM_WIDTH = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [15:0]                 cmd_data,
  output logic [VECTOR_RAM_WIDTH-1:0] vram_addr,
  output logic [7:0]                  vram_data,
  output logic                        vram_write,
  output logic                        line_open,
  output logic [VECTOR_RAM_WIDTH-1:0] list_end,
  output logic                        overflow
);

  localparam int AW = VECTOR_RAM_WIDTH;
  // RAM size in bytes, held in AW+1 bits so the capacity checks never wrap.
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  // A line may hold at most 257 points so that L = points-2 fits in a byte.
  localparam logic [8:0] MAX_POINTS = 9'd257;

  typedef enum logic [1:0] {
    OP_BEGIN = 2'd0,
    OP_POINT = 2'd1,
    OP_END   = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_INIT,        // write the initial terminator at address 0
    S_IDLE,        // cmd_ready high, waiting for a command
    S_BEGIN_ATTR,  // second BEGIN write: attribute byte
    S_POINT_Y,     // second POINT write: Y byte
    S_END_DUP_Y,   // two-point END: duplicated Y byte
    S_END_TERM,    // two-point END: terminator after the duplicate
    S_END_LEN,     // final END write: patch L at line_start
    S_DONE         // one cycle after the last write, re-raise cmd_ready
  } state_t;

  state_t         state;
  logic [AW-1:0]  ptr;          // next free byte; also the list terminator when no line is open
  logic [AW-1:0]  line_start;   // address of the open line's length byte
  logic [8:0]     point_count;  // points accepted into the open line
  logic [7:0]     attr_q;
  logic [7:0]     last_x;
  logic [7:0]     last_y;

  // A new BEGIN discards any open line first, so it builds from line_start.
  logic [AW-1:0]  begin_base;
  logic           begin_fits;
  logic           point_fits;

  assign begin_base = line_open ? line_start : ptr;
  // BEGIN needs L, attr and a byte left over for the terminator.
  assign begin_fits = ({1'b0, begin_base} + (AW+1)'(3)) <= DEPTH;
  // A point needs X,Y, room for a possible duplicated X,Y at END, and a terminator.
  assign point_fits = (({1'b0, ptr} + (AW+1)'(5)) <= DEPTH) && (point_count != MAX_POINTS);

  // Command sequencer: accepts a command in S_IDLE and emits its RAM writes
  // on consecutive cycles, all outputs registered.
  // NOTE: every register here is assigned with <= so that all state updates
  // within a cycle see the pre-edge values; mixing in = would create ordering bugs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_INIT;
      ptr         <= '0;
      line_start  <= '0;
      point_count <= '0;
      attr_q      <= '0;
      last_x      <= '0;
      last_y      <= '0;
      line_open   <= 1'b0;
      overflow    <= 1'b0;
      cmd_ready   <= 1'b0;
      vram_write  <= 1'b0;
      vram_addr   <= '0;
      vram_data   <= '0;
      list_end    <= '0;
    end else begin
      vram_write <= 1'b0;
      case (state)
        S_INIT: begin
          vram_write <= 1'b1;
          vram_addr  <= '0;
          vram_data  <= 8'h00;
          state      <= S_DONE;
        end

        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            state     <= S_DONE;
            case (op_t'(cmd_op))
              OP_BEGIN: begin
                if (begin_fits) begin
                  // Provisional L=0 doubles as the list terminator until END.
                  line_start  <= begin_base;
                  list_end    <= begin_base;
                  line_open   <= 1'b1;
                  point_count <= '0;
                  attr_q      <= cmd_data[7:0];
                  vram_write  <= 1'b1;
                  vram_addr   <= begin_base;
                  vram_data   <= 8'h00;
                  state       <= S_BEGIN_ATTR;
                end else begin
                  overflow  <= 1'b1;
                  ptr       <= begin_base;
                  list_end  <= begin_base;
                  line_open <= 1'b0;
                end
              end

              OP_POINT: begin
                if (line_open) begin
                  if (point_fits) begin
                    last_x     <= cmd_data[7:0];
                    last_y     <= cmd_data[15:8];
                    vram_write <= 1'b1;
                    vram_addr  <= ptr;
                    vram_data  <= cmd_data[7:0];
                    state      <= S_POINT_Y;
                  end else begin
                    overflow <= 1'b1;
                  end
                end
              end

              OP_END: begin
                if (line_open) begin
                  if (point_count < 9'd2) begin
                    // Too short to draw: drop it, the provisional 0 stays as terminator.
                    ptr       <= line_start;
                    list_end  <= line_start;
                    line_open <= 1'b0;
                  end else if (point_count == 9'd2) begin
                    // Pad to three points with a zero-length final segment.
                    vram_write <= 1'b1;
                    vram_addr  <= ptr;
                    vram_data  <= last_x;
                    state      <= S_END_DUP_Y;
                  end else begin
                    vram_write <= 1'b1;
                    vram_addr  <= ptr;
                    vram_data  <= 8'h00;
                    state      <= S_END_LEN;
                  end
                end
              end

              OP_CLEAR: begin
                vram_write <= 1'b1;
                vram_addr  <= '0;
                vram_data  <= 8'h00;
                ptr        <= '0;
                list_end   <= '0;
                line_open  <= 1'b0;
                overflow   <= 1'b0;
              end
            endcase
          end
        end

        S_BEGIN_ATTR: begin
          vram_write <= 1'b1;
          vram_addr  <= line_start + AW'(1);
          vram_data  <= attr_q;
          ptr        <= line_start + AW'(2);
          state      <= S_DONE;
        end

        S_POINT_Y: begin
          vram_write  <= 1'b1;
          vram_addr   <= ptr + AW'(1);
          vram_data   <= last_y;
          ptr         <= ptr + AW'(2);
          point_count <= point_count + 9'd1;
          state       <= S_DONE;
        end

        S_END_DUP_Y: begin
          vram_write  <= 1'b1;
          vram_addr   <= ptr + AW'(1);
          vram_data   <= last_y;
          ptr         <= ptr + AW'(2);
          point_count <= point_count + 9'd1;
          state       <= S_END_TERM;
        end

        S_END_TERM: begin
          vram_write <= 1'b1;
          vram_addr  <= ptr;
          vram_data  <= 8'h00;
          state      <= S_END_LEN;
        end

        S_END_LEN: begin
          // Patching L last makes the whole line appear in one write.
          vram_write <= 1'b1;
          vram_addr  <= line_start;
          vram_data  <= 8'(point_count - 9'd2);
          line_open  <= 1'b0;
          list_end   <= ptr;
          state      <= S_DONE;
        end

        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule
